// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: stall/flush control, load-use hazard detection and MEM/WB operand forwarding.
// Build option: define FORWARDING_EN for forwarding; without it the stage interlocks on EX/MEM producers instead.
module id_ex_stage #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic                      STALL,
   input  logic                      FLUSH,
   input  logic                      ID_VALID,
   input  logic [DATA_WIDTH-1:0]     ID_PC,
   input  logic [DATA_WIDTH-1:0]     ID_DATA1,
   input  logic [DATA_WIDTH-1:0]     ID_DATA2,
   input  logic [DATA_WIDTH-1:0]     ID_IMM,
   input  logic [REG_ADDR_WIDTH-1:0] ID_RS1,
   input  logic [REG_ADDR_WIDTH-1:0] ID_RS2,
   input  logic [REG_ADDR_WIDTH-1:0] ID_RD,
   input  logic [4:0]                ID_ALU_SELECT,
   input  logic                      ID_OP1_SEL,
   input  logic                      ID_OP2_SEL,
   input  logic                      ID_REG_WRITE,
   input  logic                      ID_MEM_READ,
   input  logic                      ID_MEM_WRITE,
   input  logic [REG_ADDR_WIDTH-1:0] MEM_RD,
   input  logic                      MEM_REG_WRITE,
   input  logic [DATA_WIDTH-1:0]     MEM_RESULT,
   input  logic [REG_ADDR_WIDTH-1:0] WB_RD,
   input  logic                      WB_REG_WRITE,
   input  logic [DATA_WIDTH-1:0]     WB_RESULT,
   output logic [DATA_WIDTH-1:0]     EX_DATA1,
   output logic [DATA_WIDTH-1:0]     EX_DATA2,
   output logic [4:0]                EX_SELECT,
   output logic [DATA_WIDTH-1:0]     EX_STORE_DATA,
   output logic [REG_ADDR_WIDTH-1:0] EX_RD,
   output logic                      EX_REG_WRITE,
   output logic                      EX_MEM_READ,
   output logic                      EX_MEM_WRITE,
   output logic                      EX_VALID,
   output logic                      LOAD_USE_STALL
);
   // ALU opcode that passes DATA1 through unchanged; used for bubbles
   localparam logic [4:0] ALU_FORWARD = 5'd31;

   typedef struct packed {
      logic                      valid;
      logic [DATA_WIDTH-1:0]     pc;
      logic [DATA_WIDTH-1:0]     rs1_val;
      logic [DATA_WIDTH-1:0]     rs2_val;
      logic [DATA_WIDTH-1:0]     imm;
      logic [REG_ADDR_WIDTH-1:0] rs1;
      logic [REG_ADDR_WIDTH-1:0] rs2;
      logic [REG_ADDR_WIDTH-1:0] rd;
      logic [4:0]                alu_sel;
      logic                      op1_sel;
      logic                      op2_sel;
      logic                      reg_write;
      logic                      mem_read;
      logic                      mem_write;
   } stage_t;

   function automatic stage_t bubble();
      stage_t b;
      b = '0;
      b.alu_sel = ALU_FORWARD;
      return b;
   endfunction

   stage_t                stage_d, stage_q;
   logic                  hazard;
   logic [DATA_WIDTH-1:0] fwd_rs1, fwd_rs2;

`ifdef FORWARDING_EN
   // Only a load in EX cannot be forwarded in time; everything else comes from MEM/WB
   assign hazard = stage_q.valid & stage_q.mem_read & (stage_q.rd != '0) & ID_VALID &
                   ((ID_RS1 == stage_q.rd) | (ID_RS2 == stage_q.rd));

   always_comb begin
      fwd_rs1 = stage_q.rs1_val;
      if ((stage_q.rs1 != '0) && MEM_REG_WRITE && (stage_q.rs1 == MEM_RD))
         fwd_rs1 = MEM_RESULT;
      else if ((stage_q.rs1 != '0) && WB_REG_WRITE && (stage_q.rs1 == WB_RD))
         fwd_rs1 = WB_RESULT;

      fwd_rs2 = stage_q.rs2_val;
      if ((stage_q.rs2 != '0) && MEM_REG_WRITE && (stage_q.rs2 == MEM_RD))
         fwd_rs2 = MEM_RESULT;
      else if ((stage_q.rs2 != '0) && WB_REG_WRITE && (stage_q.rs2 == WB_RD))
         fwd_rs2 = WB_RESULT;
   end
`else
   function automatic logic src_hit(input logic [REG_ADDR_WIDTH-1:0] src,
                                    input logic [REG_ADDR_WIDTH-1:0] ex_rd,
                                    input logic                      ex_wr,
                                    input logic [REG_ADDR_WIDTH-1:0] mem_rd,
                                    input logic                      mem_wr);
      return (src != '0) & ((ex_wr & (src == ex_rd)) | (mem_wr & (src == mem_rd)));
   endfunction

   // Without forwarding, any producer still in EX or MEM blocks the reader in ID
   assign hazard = ID_VALID &
      (src_hit(ID_RS1, stage_q.rd, stage_q.valid & stage_q.reg_write, MEM_RD, MEM_REG_WRITE) |
       src_hit(ID_RS2, stage_q.rd, stage_q.valid & stage_q.reg_write, MEM_RD, MEM_REG_WRITE));

   assign fwd_rs1 = stage_q.rs1_val;
   assign fwd_rs2 = stage_q.rs2_val;

   logic unused_fwd_inputs;
   assign unused_fwd_inputs = ^{WB_RD, WB_REG_WRITE, WB_RESULT, MEM_RESULT, stage_q.rs1, stage_q.rs2};
`endif

   assign LOAD_USE_STALL = hazard & ~FLUSH & RESET;

   always_comb begin
      stage_d = stage_q;
      if (FLUSH) begin
         stage_d = bubble();
      end else if (!STALL) begin
         if (LOAD_USE_STALL) begin
            stage_d = bubble();
         end else begin
            stage_d.valid     = ID_VALID;
            stage_d.pc        = ID_PC;
            stage_d.rs1_val   = ID_DATA1;
            stage_d.rs2_val   = ID_DATA2;
            stage_d.imm       = ID_IMM;
            stage_d.rs1       = ID_RS1;
            stage_d.rs2       = ID_RS2;
            stage_d.rd        = ID_RD;
            stage_d.alu_sel   = ID_ALU_SELECT;
            stage_d.op1_sel   = ID_OP1_SEL;
            stage_d.op2_sel   = ID_OP2_SEL;
            stage_d.reg_write = ID_REG_WRITE;
            stage_d.mem_read  = ID_MEM_READ;
            stage_d.mem_write = ID_MEM_WRITE;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) stage_q <= bubble();
      else        stage_q <= stage_d;
   end

   assign EX_DATA1      = stage_q.op1_sel ? stage_q.pc : fwd_rs1;
   assign EX_DATA2      = stage_q.op2_sel ? stage_q.imm : fwd_rs2;
   assign EX_STORE_DATA = fwd_rs2;
   assign EX_SELECT     = stage_q.alu_sel;
   assign EX_RD         = stage_q.rd;
   assign EX_VALID      = stage_q.valid;
   assign EX_REG_WRITE  = stage_q.reg_write & stage_q.valid;
   assign EX_MEM_READ   = stage_q.mem_read & stage_q.valid;
   assign EX_MEM_WRITE  = stage_q.mem_write & stage_q.valid;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX outputs are queued when ID is driven and compared after the edge.
// Expectations follow FORWARDING_EN the same way the design build does.
module tb_id_ex_stage;
   localparam logic [4:0] SEL_ADD     = 5'd0;
   localparam logic [4:0] SEL_SLL     = 5'd2;
   localparam logic [4:0] SEL_FORWARD = 5'd31;

   logic        CLK = 0, RESET = 1, STALL = 0, FLUSH = 0, ID_VALID = 0;
   logic [31:0] ID_PC = 0, ID_DATA1 = 0, ID_DATA2 = 0, ID_IMM = 0;
   logic [4:0]  ID_RS1 = 0, ID_RS2 = 0, ID_RD = 0, ID_ALU_SELECT = 0;
   logic        ID_OP1_SEL = 0, ID_OP2_SEL = 0, ID_REG_WRITE = 0, ID_MEM_READ = 0, ID_MEM_WRITE = 0;
   logic [4:0]  MEM_RD = 0, WB_RD = 0;
   logic        MEM_REG_WRITE = 0, WB_REG_WRITE = 0;
   logic [31:0] MEM_RESULT = 0, WB_RESULT = 0;
   logic [31:0] EX_DATA1, EX_DATA2, EX_STORE_DATA;
   logic [4:0]  EX_SELECT, EX_RD;
   logic        EX_REG_WRITE, EX_MEM_READ, EX_MEM_WRITE, EX_VALID, LOAD_USE_STALL;

   always #5 CLK = ~CLK;

   id_ex_stage dut (
      .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH), .ID_VALID(ID_VALID),
      .ID_PC(ID_PC), .ID_DATA1(ID_DATA1), .ID_DATA2(ID_DATA2), .ID_IMM(ID_IMM),
      .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_RD(ID_RD), .ID_ALU_SELECT(ID_ALU_SELECT),
      .ID_OP1_SEL(ID_OP1_SEL), .ID_OP2_SEL(ID_OP2_SEL), .ID_REG_WRITE(ID_REG_WRITE),
      .ID_MEM_READ(ID_MEM_READ), .ID_MEM_WRITE(ID_MEM_WRITE),
      .MEM_RD(MEM_RD), .MEM_REG_WRITE(MEM_REG_WRITE), .MEM_RESULT(MEM_RESULT),
      .WB_RD(WB_RD), .WB_REG_WRITE(WB_REG_WRITE), .WB_RESULT(WB_RESULT),
      .EX_DATA1(EX_DATA1), .EX_DATA2(EX_DATA2), .EX_SELECT(EX_SELECT),
      .EX_STORE_DATA(EX_STORE_DATA), .EX_RD(EX_RD), .EX_REG_WRITE(EX_REG_WRITE),
      .EX_MEM_READ(EX_MEM_READ), .EX_MEM_WRITE(EX_MEM_WRITE), .EX_VALID(EX_VALID),
      .LOAD_USE_STALL(LOAD_USE_STALL)
   );

   typedef struct {
      logic        valid;
      logic [31:0] pc, d1, d2, imm;
      logic [4:0]  rs1, rs2, rd, sel;
      logic        op1, op2, rw, mr, mw;
   } instr_t;

   typedef struct {
      string       tag;
      logic [31:0] d1, d2, st;
      logic [4:0]  sel, rd;
      logic        valid, rw, mr, mw;
   } exp_t;

   exp_t   exp_q[$];
   int     n_checks = 0;
   int     n_errors = 0;
   instr_t bub, addi, i2, i3, lw, dep, ld2, y, sw, add7, use7;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Expected operand for a source register given the MEM/WB values currently on the ports
   function automatic logic [31:0] src_val(input logic [4:0] rs, input logic [31:0] rf);
      logic [31:0] r;
      r = (rs == 5'd0) ? 32'd0 : rf;
`ifdef FORWARDING_EN
      if (rs != 5'd0 && WB_REG_WRITE && rs == WB_RD)   r = WB_RESULT;
      if (rs != 5'd0 && MEM_REG_WRITE && rs == MEM_RD) r = MEM_RESULT;
`endif
      return r;
   endfunction

   function automatic exp_t model(input string tag, input instr_t i);
      exp_t e;
      e.tag   = tag;
      e.d1    = i.op1 ? i.pc : src_val(i.rs1, i.d1);
      e.d2    = i.op2 ? i.imm : src_val(i.rs2, i.d2);
      e.st    = src_val(i.rs2, i.d2);
      e.sel   = i.sel;
      e.rd    = i.rd;
      e.valid = i.valid;
      e.rw    = i.rw & i.valid;
      e.mr    = i.mr & i.valid;
      e.mw    = i.mw & i.valid;
      return e;
   endfunction

   task automatic drive(input instr_t i);
      ID_VALID = i.valid; ID_PC = i.pc; ID_DATA1 = i.d1; ID_DATA2 = i.d2; ID_IMM = i.imm;
      ID_RS1 = i.rs1; ID_RS2 = i.rs2; ID_RD = i.rd; ID_ALU_SELECT = i.sel;
      ID_OP1_SEL = i.op1; ID_OP2_SEL = i.op2;
      ID_REG_WRITE = i.rw; ID_MEM_READ = i.mr; ID_MEM_WRITE = i.mw;
   endtask

   task automatic set_mw(input logic [4:0] mrd, input logic mrw, input logic [31:0] mres,
                         input logic [4:0] wrd, input logic wrw, input logic [31:0] wres);
      MEM_RD = mrd; MEM_REG_WRITE = mrw; MEM_RESULT = mres;
      WB_RD = wrd; WB_REG_WRITE = wrw; WB_RESULT = wres;
   endtask

   task automatic expect_next(input string tag, input instr_t i);
      exp_q.push_back(model(tag, i));
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_ex();
      exp_t e;
      check("sb_depth", 32'(exp_q.size()), 32'd1);
      if (exp_q.size() == 0) return;
      e = exp_q.pop_front();
      $display("txn %s: valid=%0b sel=%0d rd=%0d d1=%h d2=%h st=%h",
               e.tag, EX_VALID, EX_SELECT, EX_RD, EX_DATA1, EX_DATA2, EX_STORE_DATA);
      check({e.tag, ".valid"}, 32'(EX_VALID), 32'(e.valid));
      check({e.tag, ".sel"},   32'(EX_SELECT), 32'(e.sel));
      check({e.tag, ".rd"},    32'(EX_RD), 32'(e.rd));
      check({e.tag, ".d1"},    EX_DATA1, e.d1);
      check({e.tag, ".d2"},    EX_DATA2, e.d2);
      check({e.tag, ".st"},    EX_STORE_DATA, e.st);
      check({e.tag, ".rw"},    32'(EX_REG_WRITE), 32'(e.rw));
      check({e.tag, ".mr"},    32'(EX_MEM_READ), 32'(e.mr));
      check({e.tag, ".mw"},    32'(EX_MEM_WRITE), 32'(e.mw));
   endtask

   task automatic idle();
      drive(bub);
      expect_next("idle", bub);
      step();
      check_ex();
   endtask

   initial begin
      bub = '{default: '0};
      bub.sel = SEL_FORWARD;
      drive(bub);
      #2 RESET = 0;
      #10;
      expect_next("reset", bub);
      check_ex();
      check("reset_lus", 32'(LOAD_USE_STALL), 32'd0);
      @(negedge CLK) RESET = 1;

      // addi x5,x0,7 then asynchronous reset mid-cycle
      addi = bub; addi.valid = 1; addi.pc = 32'h100; addi.imm = 32'd7; addi.rd = 5;
      addi.sel = SEL_ADD; addi.op2 = 1; addi.rw = 1;
      drive(addi); expect_next("addi", addi); step(); check_ex();
      drive(bub);
      #2 RESET = 0;
      #1 expect_next("async_reset", bub); check_ex();
      check("async_reset_lus", 32'(LOAD_USE_STALL), 32'd0);
      #1 RESET = 1;
      idle();

      // forwarding priority on rs1
      i2 = bub; i2.valid = 1; i2.pc = 32'h200; i2.d1 = 32'h10; i2.d2 = 32'h20;
      i2.rs1 = 3; i2.rs2 = 9; i2.rd = 8; i2.sel = SEL_ADD; i2.rw = 1;
      drive(i2); expect_next("fwd_none", i2); step(); check_ex();
      drive(bub);
      set_mw(3, 1, 32'hAA, 3, 1, 32'hBB); #1;
      expect_next("fwd_mem", i2); check_ex();
      set_mw(3, 0, 32'hAA, 3, 1, 32'hBB); #1;
      expect_next("fwd_wb", i2); check_ex();
      i3 = bub; i3.valid = 1; i3.pc = 32'h208; i3.rd = 1; i3.sel = SEL_ADD; i3.rw = 1;
      set_mw(0, 1, 32'hAA, 0, 1, 32'hBB);
      drive(i3); expect_next("fwd_x0", i3); step(); check_ex();
      set_mw(0, 0, 0, 0, 0, 0);
      idle();

      // load-use: lw x4 in EX, dependent reads x4 through rs2
      lw = bub; lw.valid = 1; lw.pc = 32'h300; lw.d1 = 32'h1000; lw.rs1 = 2; lw.imm = 32'd4;
      lw.rd = 4; lw.sel = SEL_ADD; lw.op2 = 1; lw.rw = 1; lw.mr = 1;
      drive(lw); expect_next("lw", lw); step(); check_ex();
      dep = bub; dep.valid = 1; dep.pc = 32'h304; dep.rs1 = 1; dep.d1 = 32'd5; dep.rs2 = 4;
      dep.d2 = 32'hDEAD; dep.rd = 9; dep.sel = SEL_ADD; dep.rw = 1;
      drive(dep); #1;
      check("lus_ex", 32'(LOAD_USE_STALL), 32'd1);
      expect_next("lu_bubble", bub); step(); check_ex();
      set_mw(4, 1, 32'h77, 0, 0, 0); #1;
`ifdef FORWARDING_EN
      check("lus_mem", 32'(LOAD_USE_STALL), 32'd0);
      expect_next("lu_dep", dep); step(); check_ex();
`else
      check("lus_mem", 32'(LOAD_USE_STALL), 32'd1);
      expect_next("lu_bubble2", bub); step(); check_ex();
      set_mw(0, 0, 0, 4, 1, 32'h77);
      dep.d2 = 32'h77; drive(dep); #1;
      check("lus_wb", 32'(LOAD_USE_STALL), 32'd0);
      expect_next("lu_dep", dep); step(); check_ex();
`endif
      set_mw(0, 0, 0, 0, 0, 0);
      idle();

      // STALL holds EX (even against a pending load-use), FLUSH overrides STALL
      ld2 = bub; ld2.valid = 1; ld2.pc = 32'h400; ld2.d1 = 32'h11; ld2.d2 = 32'h22;
      ld2.rs1 = 10; ld2.rs2 = 11; ld2.rd = 12; ld2.sel = SEL_SLL; ld2.rw = 1; ld2.mr = 1;
      drive(ld2); expect_next("stall_load", ld2); step(); check_ex();
      STALL = 1;
      for (int k = 0; k < 3; k++) begin
         y = bub; y.valid = 1; y.pc = 32'h404 + 32'(4 * k); y.rs1 = 12; y.rs2 = 5'(k + 1);
         y.d1 = $urandom; y.d2 = $urandom; y.rd = 5'(20 + k); y.sel = SEL_ADD; y.rw = 1;
         drive(y); #1;
         check("lus_hold", 32'(LOAD_USE_STALL), 32'd1);
         expect_next("stall_hold", ld2); step(); check_ex();
      end
      FLUSH = 1; #1;
      check("lus_flush", 32'(LOAD_USE_STALL), 32'd0);
      expect_next("flush", bub); step(); check_ex();
      FLUSH = 0; STALL = 0;
      idle();

      // store: rs2 forwarded from WB goes to store data, immediate goes to DATA2
      set_mw(0, 0, 0, 6, 1, 32'h1234);
      sw = bub; sw.valid = 1; sw.pc = 32'h500; sw.d1 = 32'h2000; sw.rs1 = 1; sw.rs2 = 6;
      sw.d2 = 32'h55; sw.imm = 32'h8; sw.sel = SEL_ADD; sw.op2 = 1; sw.mw = 1;
      drive(sw); expect_next("store", sw); step(); check_ex();
      set_mw(0, 0, 0, 0, 0, 0);
      idle();

      // ALU producer x7 followed by a reader of x7
      add7 = bub; add7.valid = 1; add7.pc = 32'h600; add7.rs1 = 1; add7.rs2 = 2;
      add7.d1 = 32'd3; add7.d2 = 32'd4; add7.rd = 7; add7.sel = SEL_ADD; add7.rw = 1;
      drive(add7); expect_next("add7", add7); step(); check_ex();
      use7 = bub; use7.valid = 1; use7.pc = 32'h604; use7.rs1 = 7; use7.d1 = 32'hBAD;
      use7.rd = 8; use7.sel = SEL_ADD; use7.rw = 1; use7.op1 = 0;
      drive(use7); #1;
`ifdef FORWARDING_EN
      check("lus_alu", 32'(LOAD_USE_STALL), 32'd0);
      set_mw(7, 1, 32'd7, 0, 0, 0);
      expect_next("alu_dep", use7); step(); check_ex();
`else
      check("lus_alu_ex", 32'(LOAD_USE_STALL), 32'd1);
      expect_next("alu_bubble1", bub); step(); check_ex();
      set_mw(7, 1, 32'd7, 0, 0, 0); #1;
      check("lus_alu_mem", 32'(LOAD_USE_STALL), 32'd1);
      expect_next("alu_bubble2", bub); step(); check_ex();
      set_mw(0, 0, 0, 7, 1, 32'd7);
      use7.d1 = 32'd7; drive(use7); #1;
      check("lus_alu_wb", 32'(LOAD_USE_STALL), 32'd0);
      expect_next("alu_dep", use7); step(); check_ex();
`endif
      set_mw(0, 0, 0, 0, 0, 0);
      idle();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
